// File: rtl/tap_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module     : tap_generator_pkg
// Description: Shared definitions for the tap generator: debounce FSM state
//              encoding and the width of the emitted-tap counter.
// Revision   : 1.0 - initial release
// ============================================================================
package tap_generator_pkg;

    // Width of the tap counter presented on tap_count.
    localparam int TAP_COUNT_W = 8;

    // Debounce FSM encoding (2 bits, fixed values).
    localparam logic [1:0] c_ST_IDLE         = 2'd0;
    localparam logic [1:0] c_ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_HELD         = 2'd2;
    localparam logic [1:0] c_ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE         = c_ST_IDLE,
        PRESS_WAIT   = c_ST_PRESS_WAIT,
        HELD         = c_ST_HELD,
        RELEASE_WAIT = c_ST_RELEASE_WAIT
    } deb_state_t;

endpackage
`default_nettype wire

// File: rtl/tap_generator_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module     : key_debouncer
// Description: Two-flop synchronizer for a raw active-low pushbutton followed
//              by a four-state debounce FSM with a saturating stability
//              counter. A level change is accepted only after DEBOUNCE_CYCLES
//              consecutive samples at the new level (counted after the sample
//              that left the stable state).
// Ports      : clk, rst          - clock, asynchronous active-high reset
//              i_key_n           - raw pushbutton, active low, asynchronous
//              o_key_level       - debounced key state, 1 = pressed
//              o_accept          - combinational: press accepted this edge
//              o_held            - FSM currently in HELD
//              o_held_enter      - combinational: FSM enters HELD this edge
// Revision   : 1.0 - initial release
// ============================================================================
module key_debouncer
    import tap_generator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_key_level,
    output logic o_accept,
    output logic o_held,
    output logic o_held_enter
);

    // Terminal count: the edge on which the last required stable sample is seen.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // Synchronizer flops hold the raw (active-low) level; reset = released.
    logic r_sync1;
    logic r_sync2;
    logic w_pressed;

    deb_state_t       r_state;
    deb_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_key_level;
    logic             w_key_level_next;
    logic             w_accept;
    logic             w_held_enter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_key_level <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_key_level <= w_key_level_next;
        end
    end

    // The counter is only non-zero in the two WAIT states; every transition
    // loads zero so each state is entered with a fresh count, and any sample
    // that breaks stability leaves the WAIT state with the count cleared.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_key_level_next = r_key_level;
        w_accept         = 1'b0;
        w_held_enter     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pressed) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_pressed) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next     = HELD;
                    w_cnt_next       = '0;
                    w_key_level_next = 1'b1;
                    w_accept         = 1'b1;
                    w_held_enter     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
            HELD: begin
                if (!w_pressed) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_pressed) begin
                    w_state_next = HELD;
                    w_cnt_next   = '0;
                    w_held_enter = 1'b1;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next     = IDLE;
                    w_cnt_next       = '0;
                    w_key_level_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_key_level  = r_key_level;
    assign o_accept     = w_accept;
    assign o_held       = (r_state == HELD);
    assign o_held_enter = w_held_enter;

endmodule
`default_nettype wire

// File: rtl/tap_generator.sv
`default_nettype none
// ============================================================================
// Module     : tap_generator
// Description: Turns a bouncy active-low pushbutton into single-cycle tap
//              pulses aligned to the game tick. An accepted press marks a tap
//              pending; the next game_tick (including one on the accept edge)
//              emits it. Presses accepted between ticks coalesce.
// Config     : TAP_AUTO_REPEAT_EN - when defined, a held key re-arms a tap
//              every REPEAT_TICKS game ticks (counted since the last tap
//              while HELD; cleared on entering HELD).
// Ports      : clock, reset  - system clock, asynchronous active-high reset
//              key_n         - raw pushbutton, active low, asynchronous
//              game_tick     - one-cycle game update strobe
//              tap           - registered one-cycle tap pulse
//              key_level     - debounced key state, 1 = pressed
//              tap_count     - number of taps emitted (wraps)
// Revision   : 1.0 - initial release
// ============================================================================
module tap_generator
    import tap_generator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int REPEAT_TICKS    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   key_n,
    input  logic                   game_tick,
    output logic                   tap,
    output logic                   key_level,
    output logic [TAP_COUNT_W-1:0] tap_count
);

    logic                   w_accept;
    logic                   w_held;
    logic                   w_held_enter;
    logic                   w_fire;
    logic                   w_set;
    logic                   w_emit;
    logic                   r_pending;
    logic                   r_tap;
    logic [TAP_COUNT_W-1:0] r_tap_count;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_key_debouncer (
        .clk          (clock),
        .rst          (reset),
        .i_key_n      (key_n),
        .o_key_level  (key_level),
        .o_accept     (w_accept),
        .o_held       (w_held),
        .o_held_enter (w_held_enter)
    );

`ifdef TAP_AUTO_REPEAT_EN
    localparam int                c_REP_W    = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_TICKS - 1);

    // Counts game ticks spent in HELD since the last emitted tap; the tick
    // that reaches the terminal count re-arms a tap on the same edge.
    logic [c_REP_W-1:0] r_rep_cnt;

    assign w_fire = w_held & game_tick & (r_rep_cnt == c_REP_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rep_cnt <= '0;
        end else if (w_held_enter) begin
            r_rep_cnt <= '0;
        end else if (w_held && game_tick) begin
            r_rep_cnt <= w_emit ? '0 : (r_rep_cnt + c_REP_W'(1));
        end
    end
`else
    localparam int c_unused_repeat_ticks = REPEAT_TICKS;
    logic          w_unused_held;

    assign w_fire        = 1'b0;
    assign w_unused_held = w_held ^ w_held_enter;
`endif

    // A request raised on this edge is visible to the same game_tick.
    assign w_set  = w_accept | w_fire;
    assign w_emit = game_tick & (r_pending | w_set);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending   <= 1'b0;
            r_tap       <= 1'b0;
            r_tap_count <= '0;
        end else begin
            r_tap <= w_emit;
            if (w_emit) begin
                r_pending   <= 1'b0;
                r_tap_count <= r_tap_count + TAP_COUNT_W'(1);
            end else if (w_set) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign tap       = r_tap;
    assign tap_count = r_tap_count;

endmodule
`default_nettype wire

// File: tb/tb_tap_generator.sv
`default_nettype none
// ============================================================================
// Module     : tb_tap_generator
// Description: Self-checking bench for tap_generator (DEBOUNCE_CYCLES=4,
//              REPEAT_TICKS=3). A behavioural model derives key_level from
//              the history of synchronized samples (a level flips once the
//              last DEBOUNCE_CYCLES+1 samples all disagree with it) and tracks
//              pending/tap/tap_count from the tick rules.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_tap_generator;

    localparam int D  = 4;
    localparam int CW = 4;
    localparam int R  = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_n;
    logic       game_tick;
    logic       tap;
    logic       key_level;
    logic [7:0] tap_count;

    int checks   = 0;
    int failures = 0;

    tap_generator #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .REPEAT_TICKS    (R)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_n),
        .game_tick (game_tick),
        .tap       (tap),
        .key_level (key_level),
        .tap_count (tap_count)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    bit m_pipe[$];      // key_n values still inside the synchronizer
    bit m_hist[$];      // most recent synchronized "pressed" samples
    bit m_level;
    bit m_pending;
    bit m_tap;
    int m_count;
    bit m_held;
    int m_ticks;

    int tick_period;
    int tick_phase;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit k, input bit tick, input bit rst);
        bit sample, pressed, flip, accept, fire, emit, held_now;
        if (rst) begin
            m_pipe = '{1'b1, 1'b1};
            m_hist.delete();
            m_level = 0; m_pending = 0; m_tap = 0; m_count = 0;
            m_held = 0; m_ticks = 0;
            return;
        end
        sample = m_pipe.pop_front();
        m_pipe.push_back(k);
        pressed = !sample;
        m_hist.push_back(pressed);
        if (m_hist.size() > D + 1) void'(m_hist.pop_front());
        flip = (m_hist.size() == D + 1);
        foreach (m_hist[i]) if (m_hist[i] == m_level) flip = 0;
        accept = 0;
        if (flip) begin
            m_level = !m_level;
            accept  = m_level;
        end
        held_now = m_level && pressed;
        fire = 0;
`ifdef TAP_AUTO_REPEAT_EN
        if (m_held && tick && m_ticks == R - 1) fire = 1;
`endif
        emit = tick && (m_pending || accept || fire);
`ifdef TAP_AUTO_REPEAT_EN
        if (held_now && !m_held) m_ticks = 0;
        else if (m_held && tick) m_ticks = emit ? 0 : m_ticks + 1;
`endif
        m_tap = emit;
        if (emit) begin
            m_pending = 0;
            m_count   = (m_count + 1) % 256;
        end else if (accept || fire) begin
            m_pending = 1;
        end
        m_held = held_now;
    endtask

    // One clock: drive inputs, advance DUT and model, compare after the edge.
    task automatic step(input bit k, input bit t);
        key_n     = k;
        game_tick = t;
        @(posedge clock);
        model_step(k, t, reset);
        #1;
        check_val("tap", {31'd0, tap}, {31'd0, m_tap});
        check_val("key_level", {31'd0, key_level}, {31'd0, m_level});
        check_val("tap_count", {24'd0, tap_count}, m_count);
    endtask

    task automatic run_key(input bit k, input int n);
        for (int i = 0; i < n; i++) begin
            tick_phase++;
            step(k, (tick_period != 0) && (tick_phase % tick_period == 0));
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        check_val("async_rst_tap", {31'd0, tap}, 0);
        check_val("async_rst_level", {31'd0, key_level}, 0);
        check_val("async_rst_count", {24'd0, tap_count}, 0);
        for (int i = 0; i < n; i++) step(key_n, 1'b0);
        reset = 1'b0;
        tick_phase = 0;
    endtask

    initial begin : main
        int lat;
        key_n = 1'b1; game_tick = 1'b0; reset = 1'b1;
        tick_period = 10; tick_phase = 0;
        #2;
        do_reset(2);
        check_val("reset_count", {24'd0, tap_count}, 0);

        // Clean press, ticks every 10 cycles.
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            run_key(1'b0, 1);
            if (lat < 0 && key_level) lat = i;
        end
        check_val("press_latency_ok", {31'd0, (lat >= 5 && lat <= 7)}, 1);
        run_key(1'b1, 20);
        check_val("clean_press_count", {24'd0, tap_count}, 1);
        check_val("clean_release_level", {31'd0, key_level}, 0);

        // Short bounces: never accepted.
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            run_key(1'b0, 2);
            run_key(1'b1, 2);
        end
        run_key(1'b1, 20);
        check_val("bounce_count", {24'd0, tap_count}, 0);
        check_val("bounce_level", {31'd0, key_level}, 0);

        // Two presses with no tick in between coalesce.
        do_reset(1);
        tick_period = 0;
        run_key(1'b0, 9); run_key(1'b1, 9);
        run_key(1'b0, 9); run_key(1'b1, 9);
        check_val("coalesce_pre_tick", {24'd0, tap_count}, 0);
        step(1'b1, 1'b1);
        check_val("coalesce_tap", {31'd0, tap}, 1);
        run_key(1'b1, 5);
        check_val("coalesce_count", {24'd0, tap_count}, 1);

        // Tick on the accepting edge: tap on the following cycle.
        do_reset(1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        check_val("same_edge_level_pre", {31'd0, key_level}, 0);
        step(1'b0, 1'b1);
        check_val("same_edge_level", {31'd0, key_level}, 1);
        check_val("same_edge_tap", {31'd0, tap}, 1);
        run_key(1'b1, 12);

        // Reset during PRESS_WAIT, key still held afterwards.
        do_reset(1);
        tick_period = 10;
        run_key(1'b0, 4);
        do_reset(2);
        run_key(1'b0, 25);
        check_val("rst_redebounce_level", {31'd0, key_level}, 1);
        check_val("rst_redebounce_count", {24'd0, tap_count}, 1);
        run_key(1'b1, 12);

        // Key held across ten game ticks.
        do_reset(1);
        run_key(1'b0, 101);
        run_key(1'b1, 20);
`ifdef TAP_AUTO_REPEAT_EN
        check_val("long_hold_count", {24'd0, tap_count}, 4);
`else
        check_val("long_hold_count", {24'd0, tap_count}, 1);
`endif

        // Randomized segments against the model.
        do_reset(1);
        for (int s = 0; s < 400; s++) begin
            bit k;
            int n;
            k = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) step(k, $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 120) == 0) do_reset(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
